// File: rtl/cpu_pkg.sv
// Shared CPU constants: opcodes, control-unit state codes
// and the one-hot instruction class bundle.
package cpu_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_JAL  = 5'b10100;
  localparam logic [4:0] OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  localparam logic [3:0] S_RESET = 4'b0000;
  localparam logic [3:0] S_T0    = 4'b0111;
  localparam logic [3:0] S_T1    = 4'b1000;
  localparam logic [3:0] S_T2    = 4'b1001;
  localparam logic [3:0] S_T3    = 4'b1010;
  localparam logic [3:0] S_T4    = 4'b1011;
  localparam logic [3:0] S_T5    = 4'b1100;
  localparam logic [3:0] S_T6    = 4'b1101;
  localparam logic [3:0] S_T7    = 4'b1110;
  localparam logic [3:0] S_HALT  = 4'b1111;

  typedef struct packed {
    logic ld;
    logic ldi;
    logic st;
    logic add_op;
    logic sub_op;
    logic and_op;
    logic or_op;
    logic addi;
    logic mul;
    logic div;
    logic jr;
    logic jal;
    logic mfhi;
    logic mflo;
    logic nop;
    logic halt;
    logic ill;
  } iclass_t;

endpackage

// File: rtl/control_opdecode.sv
// Opcode to one-hot instruction class; every code outside
// the defined set lands in the ill bit.
module control_opdecode
  import cpu_pkg::*;
(
  input  logic [4:0] opcode,
  output iclass_t    cls
);

  always_comb begin
    cls = '0;
    unique case (opcode)
      OP_LD:   cls.ld     = 1'b1;
      OP_LDI:  cls.ldi    = 1'b1;
      OP_ST:   cls.st     = 1'b1;
      OP_ADD:  cls.add_op = 1'b1;
      OP_SUB:  cls.sub_op = 1'b1;
      OP_AND:  cls.and_op = 1'b1;
      OP_OR:   cls.or_op  = 1'b1;
      OP_ADDI: cls.addi   = 1'b1;
      OP_MUL:  cls.mul    = 1'b1;
      OP_DIV:  cls.div    = 1'b1;
      OP_JR:   cls.jr     = 1'b1;
      OP_JAL:  cls.jal    = 1'b1;
      OP_MFHI: cls.mfhi   = 1'b1;
      OP_MFLO: cls.mflo   = 1'b1;
      OP_NOP:  cls.nop    = 1'b1;
      OP_HALT: cls.halt   = 1'b1;
      default: cls.ill    = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Moore sequencing FSM for the multi-cycle datapath:
// fetch in T0-T2, opcode-dependent execute in T3-T7.
module control_unit
  import cpu_pkg::*;
#(
  parameter bit NOP_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  output logic        run,
  output logic [3:0]  present_state,
  output logic        PCout,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        MDRout,
  output logic        Cout,
  output logic        BAout,
  output logic        HIout,
  output logic        LOout,
  output logic        IN_Portout,
  output logic        MARIn,
  output logic        PCIn,
  output logic        MDRIn,
  output logic        IRIn,
  output logic        YIn,
  output logic        ZIn,
  output logic        HiIn,
  output logic        LoIn,
  output logic        CIn,
  output logic        InIn,
  output logic        OutIn,
  output logic        CONIn,
  output logic        RIn,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rout,
  output logic        IncPC,
  output logic        read,
  output logic        write,
  output logic        add,
  output logic        subtract,
  output logic        multiply,
  output logic        divide,
  output logic        andSignal,
  output logic        orSignal
);

  logic [3:0] state;
  logic [3:0] nxt;
  iclass_t    cls;
  logic       ir_unused;
  logic       alu;
  logic       to_halt;
  logic       end3;
  logic       end5;
  logic       end6;

  assign ir_unused = ^ir[26:0];

  control_opdecode u_dec (
    .opcode (ir[31:27]),
    .cls    (cls)
  );

  assign alu = cls.add_op | cls.sub_op
             | cls.and_op | cls.or_op;

  assign to_halt = cls.halt
                 | (cls.ill & ~NOP_ON_ILLEGAL);
  assign end3 = cls.nop | cls.jr | cls.mfhi
              | cls.mflo | cls.ill;
  assign end5 = alu | cls.addi | cls.ldi;
  assign end6 = cls.mul | cls.div;

  always_ff @(posedge clk) begin
    if (clr) state <= S_RESET;
    else     state <= nxt;
  end

  always_comb begin
    nxt = S_RESET;
    unique case (state)
      S_RESET: nxt = S_T0;
      S_T0:    nxt = S_T1;
      S_T1:    nxt = S_T2;
      S_T2:    nxt = S_T3;
      S_T3:
        if (to_halt)   nxt = S_HALT;
        else if (end3) nxt = S_T0;
        else           nxt = S_T4;
      S_T4:    nxt = cls.jal ? S_T0 : S_T5;
      S_T5:    nxt = end5 ? S_T0 : S_T6;
      S_T6:    nxt = end6 ? S_T0 : S_T7;
      S_T7:    nxt = S_T0;
      S_HALT:  nxt = S_HALT;
      default: nxt = S_RESET;
    endcase
  end

  assign present_state = state;
  assign run        = (state != S_HALT);
  assign IN_Portout = 1'b0;
  assign CIn        = 1'b0;
  assign InIn       = 1'b0;
  assign OutIn      = 1'b0;
  assign CONIn      = 1'b0;

  // Strobes depend only on state and the stable IR opcode.
  always_comb begin
    PCout = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0;
    MDRout = 1'b0; Cout = 1'b0; BAout = 1'b0;
    HIout = 1'b0; LOout = 1'b0;
    MARIn = 1'b0; PCIn = 1'b0; MDRIn = 1'b0;
    IRIn = 1'b0; YIn = 1'b0; ZIn = 1'b0;
    HiIn = 1'b0; LoIn = 1'b0; RIn = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
    Rout = 1'b0; IncPC = 1'b0;
    read = 1'b0; write = 1'b0;
    add = 1'b0; subtract = 1'b0;
    multiply = 1'b0; divide = 1'b0;
    andSignal = 1'b0; orSignal = 1'b0;
    unique case (state)
      S_T0: begin
        PCout = 1'b1; MARIn = 1'b1;
        IncPC = 1'b1; ZIn = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1; PCIn = 1'b1;
        read = 1'b1; MDRIn = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1; IRIn = 1'b1;
      end
      S_T3:
        unique case (1'b1)
          alu, cls.addi: begin
            Grb = 1'b1; Rout = 1'b1; YIn = 1'b1;
          end
          cls.ldi, cls.ld, cls.st: begin
            Grb = 1'b1; BAout = 1'b1; YIn = 1'b1;
          end
          cls.mul, cls.div: begin
            Gra = 1'b1; Rout = 1'b1; YIn = 1'b1;
          end
          cls.mfhi: begin
            HIout = 1'b1; Gra = 1'b1; RIn = 1'b1;
          end
          cls.mflo: begin
            LOout = 1'b1; Gra = 1'b1; RIn = 1'b1;
          end
          cls.jr: begin
            Gra = 1'b1; Rout = 1'b1; PCIn = 1'b1;
          end
          cls.jal: begin
            PCout = 1'b1; Grb = 1'b1; RIn = 1'b1;
          end
          default: ;
        endcase
      S_T4:
        unique case (1'b1)
          alu: begin
            Grc = 1'b1; Rout = 1'b1; ZIn = 1'b1;
            add       = cls.add_op;
            subtract  = cls.sub_op;
            andSignal = cls.and_op;
            orSignal  = cls.or_op;
          end
          cls.addi, cls.ldi, cls.ld, cls.st: begin
            Cout = 1'b1; add = 1'b1; ZIn = 1'b1;
          end
          cls.mul, cls.div: begin
            Grb = 1'b1; Rout = 1'b1; ZIn = 1'b1;
            multiply = cls.mul;
            divide   = cls.div;
          end
          cls.jal: begin
            Gra = 1'b1; Rout = 1'b1; PCIn = 1'b1;
          end
          default: ;
        endcase
      S_T5:
        unique case (1'b1)
          alu, cls.addi, cls.ldi: begin
            Zlowout = 1'b1; Gra = 1'b1; RIn = 1'b1;
          end
          cls.ld, cls.st: begin
            Zlowout = 1'b1; MARIn = 1'b1;
          end
          cls.mul, cls.div: begin
            Zlowout = 1'b1; LoIn = 1'b1;
          end
          default: ;
        endcase
      S_T6:
        unique case (1'b1)
          cls.ld: begin
            read = 1'b1; MDRIn = 1'b1;
          end
          cls.st: begin
            Gra = 1'b1; Rout = 1'b1; MDRIn = 1'b1;
          end
          cls.mul, cls.div: begin
            Zhighout = 1'b1; HiIn = 1'b1;
          end
          default: ;
        endcase
      S_T7:
        unique case (1'b1)
          cls.ld: begin
            MDRout = 1'b1; Gra = 1'b1; RIn = 1'b1;
          end
          cls.st: write = 1'b1;
          default: ;
        endcase
      default: ;
    endcase
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 NOP_ON_ILLEGAL, default 1, undefined opcode: 1 = execute as nop, 0 = enter HALT.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 clr  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 ir  input  32  datapath IR contents; opcode = ir[31:27].
REQ-005 run  output  1  low only in HALT.
REQ-006 present_state  output  4  current state encoding, for debug.
REQ-007 PCout, Zlowout, Zhighout, MDRout, Cout, BAout, HIout, LOout, IN_Portout  output  1 each  bus-driver selects.
REQ-008 MARIn, PCIn, MDRIn, IRIn, YIn, ZIn, HiIn, LoIn, CIn, InIn, OutIn, CONIn, RIn  output  1 each  register load enables.
REQ-009 Gra, Grb, Grc, Rout, IncPC, read, write  output  1 each  register-field selects, PC increment, memory strobes.
REQ-010 add, subtract, multiply, divide, andSignal, orSignal  output  1 each  ALU operation selects.

Function
REQ-011 Moore FSM: every output is a pure decode of the state register, valid for the whole cycle; each state lasts exactly one clock.
REQ-012 States: RESET, T0-T7, HALT; T0-T2 = fetch, T3-T7 = execute.
REQ-013 Fetch: T0 PCout MARIn IncPC ZIn; T1 Zlowout PCIn read MDRIn; T2 MDRout IRIn.
REQ-014 Opcode decoded from ir during T3-T7 only; ir is stable from T3 until the next T2.
REQ-015 Opcodes: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 01001, or 01010, addi 01011, mul 01110, div 01111, jr 10011, jal 10100, mfhi 10111, mflo 11000, nop 11001, halt 11010.
REQ-016 add/sub/and/or: T3 Grb Rout YIn; T4 Grc Rout op ZIn; T5 Zlowout Gra RIn.
REQ-017 addi: T3 Grb Rout YIn; T4 Cout add ZIn; T5 Zlowout Gra RIn.
REQ-018 ldi: T3 Grb BAout YIn; T4 Cout add ZIn; T5 Zlowout Gra RIn.
REQ-019 ld: T3-T4 as ldi; T5 Zlowout MARIn; T6 read MDRIn; T7 MDRout Gra RIn.
REQ-020 st: T3-T4 as ldi; T5 Zlowout MARIn; T6 Gra Rout MDRIn (read=0); T7 write.
REQ-021 mul/div: T3 Gra Rout YIn; T4 Grb Rout multiply|divide ZIn; T5 Zlowout LoIn; T6 Zhighout HiIn.
REQ-022 mfhi/mflo: T3 HIout|LOout Gra RIn.
REQ-023 jr: T3 Gra Rout PCIn.
REQ-024 jal: T3 PCout Grb RIn (link into rb); T4 Gra Rout PCIn.
REQ-025 nop: T3 all outputs 0.
REQ-026 After an instruction's last step, next state is T0.
REQ-027 Total cycles: nop/jr/mfhi/mflo 4, jal 5, ALU/addi/ldi 6, mul/div 7, ld/st 8.
REQ-028 halt: T3 (all outputs 0) -> HALT; HALT holds all outputs 0, run=0, until clr.
REQ-029 Undefined opcode is handled per NOP_ON_ILLEGAL.
REQ-030 Invariants every cycle: at most one bus driver; at most one of Gra/Grb/Grc; at most one ALU op; read and write never both high.
REQ-031 IN_Portout, InIn, OutIn, CONIn, CIn are constant 0 in this revision.

Reset
REQ-032 clr high at a rising edge -> state RESET from any state, including mid-instruction and HALT.
REQ-033 In RESET: all strobes 0, run=1.
REQ-034 First edge with clr low in RESET -> T0.
REQ-035 No read or write is asserted in the cycle after clr is sampled.

Structure
REQ-036 Shared package cpu_pkg holds opcode constants and state encodings: RESET 0000, T0-T7 0111-1110, HALT 1111.
REQ-037 Sub-module control_opdecode: combinational opcode -> one-hot instruction class.
REQ-038 Sequencing FSM and output decode reside in control_unit.

Verification
REQ-039 clr=1 for 2 edges then 0 -> present_state=0000 with all outputs 0 and run=1; next cycle T0 with PCout=MARIn=IncPC=ZIn=1.
REQ-040 ir[31:27]=00011 -> T4 asserts Grc Rout add ZIn; T5 asserts Zlowout Gra RIn; T0 returns 6 cycles after the previous T0.
REQ-041 ir[31:27]=00000 -> read high in T1 and T6 only; MDRout Gra RIn in T7; 8-cycle period.
REQ-042 ir[31:27]=00010 -> write high exactly one cycle (T7), never with read; ir[31:27]=01110 -> LoIn in T5, HiIn in T6, then T0.
REQ-043 ir[31:27]=11010 -> run=0 and all outputs 0 for 20 cycles, released only by clr; clr pulsed in T5 of ld -> RESET next edge, no read/write, then T0.
REQ-044 ir[31:27]=11111: NOP_ON_ILLEGAL=1 -> 4-cycle nop; NOP_ON_ILLEGAL=0 -> HALT, run=0; invariants of REQ-030 asserted throughout all scenarios.
